// File: rtl/seq_multiplier_pkg.sv
// Shared types and defaults for the shift-add multiplier: FSM encodings, default operand width.
`ifndef SEQ_MUL_RANGE
`define SEQ_MUL_RANGE(w) ((w)-1):0
`endif

package seq_multiplier_pkg;

    localparam int DEFAULT_XLEN = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef logic [`SEQ_MUL_RANGE(DEFAULT_XLEN)] word_t;

endpackage

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add unsigned multiplier; latency XLEN+1 cycles from vld to ack.
// No backpressure: vld while busy is dropped, vld in the ack cycle starts the next operation.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [`SEQ_MUL_RANGE(XLEN)]   a,
    input  logic [`SEQ_MUL_RANGE(XLEN)]   b,
    input  logic                    vld,
    output logic [`SEQ_MUL_RANGE(2*XLEN)] prod,
    output logic                    ack,
    output logic                    busy
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

    state_e                  state_q;
    logic [2*XLEN-1:0]       mcand_q;
    logic [XLEN-1:0]         mplier_q;
    logic [2*XLEN-1:0]       acc_q;
    logic [2*XLEN-1:0]       acc_d;
    logic [CW-1:0]           cnt_q;
    logic [2*XLEN-1:0]       prod_q;
    logic                    ack_q;

    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            ack_q    <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (vld) begin
                        mcand_q  <= {{XLEN{1'b0}}, a};
                        mplier_q <= b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    // Fixed XLEN iterations; zero operands do not shorten the run.
                    if (cnt_q == LAST_ITER) begin
                        prod_q  <= acc_d;
                        ack_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign prod = prod_q;
    assign ack  = ack_q;
    assign busy = (state_q == BUSY);

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed corner cases plus random operands vs an arithmetic model.
module tb_seq_multiplier;

    localparam int XLEN = 32;

    logic                clk;
    logic                rst;
    logic [XLEN-1:0]     a;
    logic [XLEN-1:0]     b;
    logic                vld;
    logic [2*XLEN-1:0]   prod;
    logic                ack;
    logic                busy;

    int checks = 0;
    int errors = 0;

    seq_multiplier #(.XLEN(XLEN)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .vld  (vld),
        .prod (prod),
        .ack  (ack),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait (bounded) for its ack; leaves time at the ack cycle so a
    // following call is a back-to-back request.
    task automatic run_op(input string tag, input logic [XLEN-1:0] av, input logic [XLEN-1:0] bv,
                          input bit full);
        logic [63:0] p0;
        logic [63:0] expv;
        int          k;
        int          busy_cnt;
        bit          stable;
        bit          got_ack;
        expv     = 64'(av) * 64'(bv);
        p0       = prod;
        a        = av;
        b        = bv;
        vld      = 1'b1;
        tick();
        vld      = 1'b0;
        a        = $urandom;
        b        = $urandom;
        busy_cnt = 0;
        stable   = 1'b1;
        got_ack  = 1'b0;
        for (k = 0; k < XLEN + 8; k++) begin
            if (ack) begin
                got_ack = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            if (prod !== p0) stable = 1'b0;
            tick();
        end
        chk({tag, "_ack_seen"}, 64'(got_ack), 64'd1);
        chk({tag, "_prod"}, prod, expv);
        if (full) begin
            chk({tag, "_latency"}, 64'(k), 64'(XLEN));
            chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(XLEN));
            chk({tag, "_prod_stable"}, 64'(stable), 64'd1);
            chk({tag, "_busy_at_ack"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        int          acks;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] p;

        rst = 1'b1;
        vld = 1'b0;
        a   = '0;
        b   = '0;
        #1;
        chk("reset_prod", prod, 64'd0);
        chk("reset_ack", 64'(ack), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_op("basic_7x6", 32'd7, 32'd6, 1'b1);
        tick();
        chk("ack_one_cycle", 64'(ack), 64'd0);
        chk("prod_hold_idle", prod, 64'd42);

        run_op("max_x_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        chk("max_x_max_const", prod, 64'hFFFF_FFFE_0000_0001);
        tick();
        run_op("zero_x_max", 32'd0, 32'hFFFF_FFFF, 1'b1);
        tick();

        // Request arriving mid-operation must be dropped, not queued.
        a   = 32'd3;
        b   = 32'd5;
        vld = 1'b1;
        tick();
        vld = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        a   = 32'd9;
        b   = 32'd9;
        vld = 1'b1;
        tick();
        vld  = 1'b0;
        acks = 0;
        for (int i = 0; i < XLEN + 8 && acks == 0; i++) begin
            if (ack) acks++;
            else tick();
        end
        chk("drop_ack_seen", 64'(acks), 64'd1);
        chk("drop_prod", prod, 64'd15);
        acks = 0;
        for (int i = 0; i < 2 * XLEN; i++) begin
            tick();
            if (ack) acks++;
        end
        chk("drop_no_second_ack", 64'(acks), 64'd0);
        chk("drop_prod_kept", prod, 64'd15);

        run_op("b2b_first", 32'd5, 32'd7, 1'b1);
        run_op("b2b_second", 32'd100, 32'd200, 1'b1);
        tick();

        // Asynchronous reset in the middle of an operation.
        a   = 32'd1000;
        b   = 32'd1000;
        vld = 1'b1;
        tick();
        vld = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        chk("pre_reset_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("midreset_prod", prod, 64'd0);
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_ack", 64'(ack), 64'd0);
        tick();
        rst  = 1'b0;
        acks = 0;
        for (int i = 0; i < 2 * XLEN; i++) begin
            tick();
            if (ack) acks++;
        end
        chk("midreset_no_ack", 64'(acks), 64'd0);
        run_op("after_reset_2x3", 32'd2, 32'd3, 1'b1);
        tick();

        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 7))
                0: ra = 32'hFFFF_FFFF;
                1: ra = 32'd0;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'hFFFF_FFFF;
                1: rb = 32'd0;
                2: rb = 32'd1 << $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            run_op("rand", ra, rb, (n % 100) == 0);
            if (rb != 32'd0) begin
                p = prod;
                chk("rand_div_quot", p / 64'(rb), 64'(ra));
                chk("rand_div_rem", p % 64'(rb), 64'd0);
            end
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
